ccip_eth_csr_mc: RTL and testbench

// - Multi-channel CCI-P MMIO CSR block for HSSI Ethernet AFUs.
// - Decodes MMIO reads and writes into global AFU registers plus NUM_CH per-channel Ethernet CSR windows.
// - Runs one command FSM per channel, which issues read/write transactions to that channel's Ethernet MAC CSR port.
// - Returns MMIO read responses with a fixed 2-cycle latency.
// - Sits between the CCI-P interface register stage and NUM_CH eth_e2e instances. All signals are on clk; CDC is external.
//

---
 rtl/ccip_eth_csr_mc.sv | 230 +++++++++++++++++++++++
 tb/tb_ccip_eth_csr_mc.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_eth_csr_mc.sv
// CCI-P MMIO CSR block: global AFU registers plus NUM_CH Ethernet MAC CSR command channels.
// Optional feature: define CCIP_ETH_CSR_TIMEOUT_EN to abort unacknowledged requests after TIMEOUT_CYC cycles.
module ccip_eth_csr_mc #(
  parameter int          NUM_CH      = 4,
  parameter logic [63:0] AFU_ID_L    = 64'h0,
  parameter logic [63:0] AFU_ID_H    = 64'h0,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   pck_cp2af_softReset_T1,
  input  logic                   mmio_wr_en,
  input  logic                   mmio_rd_en,
  input  logic [15:0]            mmio_addr,
  input  logic [8:0]             mmio_tid,
  input  logic [63:0]            mmio_din,
  output logic                   rsp_valid,
  output logic [8:0]             rsp_tid,
  output logic [63:0]            rsp_data,
  output logic [32*NUM_CH-1:0]   eth_ctrl_addr,
  output logic [32*NUM_CH-1:0]   eth_wr_data,
  output logic [NUM_CH-1:0]      eth_req,
  input  logic [NUM_CH-1:0]      eth_ack,
  input  logic [32*NUM_CH-1:0]   eth_rd_data,
  output logic [NUM_CH-1:0]      init_start,
  input  logic [NUM_CH-1:0]      init_done
);

  localparam logic [63:0] DFH = 64'h1000_0000_0000_0001;

  typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

  logic       w_aligned, w_glb_hit, w_ch_hit;
  logic [2:0] w_glb_idx, w_ch_idx;
  logic [1:0] w_reg_idx;

  // Globals live below byte 0x40, channel windows at byte 0x100..0x1FF (mmio_addr 0x40..0x7F).
  assign w_aligned = ~mmio_addr[0];
  assign w_glb_hit = w_aligned && (mmio_addr[15:4] == 12'd0);
  assign w_ch_hit  = w_aligned && (mmio_addr[15:6] == 10'd1);
  assign w_glb_idx = mmio_addr[3:1];
  assign w_ch_idx  = mmio_addr[5:3];
  assign w_reg_idx = mmio_addr[2:1];

  logic [63:0]       r_scratch;
  logic [NUM_CH-1:0] r_init_start, r_init_done;

  // NOTE: every flop in this file, data registers included, is reset so the block is fully quiet after softReset.
  always_ff @(posedge clk or posedge pck_cp2af_softReset_T1) begin
    if (pck_cp2af_softReset_T1) begin
      r_scratch    <= '0;
      r_init_start <= '0;
      r_init_done  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
      if (mmio_wr_en && w_glb_hit && (w_glb_idx == 3'd3)) r_scratch <= mmio_din;
      if (mmio_wr_en && w_glb_hit && (w_glb_idx == 3'd4)) r_init_start <= mmio_din[NUM_CH-1:0];
      r_init_done <= init_done;
    end
  end

  assign init_start = r_init_start;

  // Channel views padded to 8 so unpopulated windows read 0 without range checks.
  logic [32*8-1:0] w_ctrl_all, w_wdat_all, w_rdat_all;
  logic [4*8-1:0]  w_stat_all;

  for (genvar ch = 0; ch < 8; ch++) begin : g_ch
    if (ch < NUM_CH) begin : g_on
      state_t      r_state, w_next;
      logic [31:0] r_ctrl, r_wr_data, r_rd_data, r_eth_addr;
      logic        r_done, r_ovr, r_tmo;
      logic        w_sel, w_wr_ctrl, w_wr_wdat, w_wr_stat;
      logic        w_start, w_fin_ack, w_fin_tmo, w_busy;
      logic [3:0]  w_clr;

      assign w_sel     = mmio_wr_en && w_ch_hit && (w_ch_idx == 3'(ch));
      assign w_wr_ctrl = w_sel && (w_reg_idx == 2'd0);
      assign w_wr_wdat = w_sel && (w_reg_idx == 2'd1);
      assign w_wr_stat = w_sel && (w_reg_idx == 2'd3);
      assign w_clr     = {4{w_wr_stat}} & mmio_din[3:0];

`ifdef CCIP_ETH_CSR_TIMEOUT_EN
      localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
      logic [CNT_W-1:0] r_cnt;
      logic             w_expire;
      assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

      always_ff @(posedge clk or posedge pck_cp2af_softReset_T1) begin
        if (pck_cp2af_softReset_T1) r_state <= ST_IDLE;
        else                        r_state <= w_next;
      end

      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_fin_ack = 1'b0;
        w_fin_tmo = 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (w_wr_ctrl && (mmio_din[17] || mmio_din[16])) begin
              w_next  = ST_REQ;
              w_start = 1'b1;
            end
          end
          ST_REQ: begin
            if (eth_ack[ch]) begin
              w_next    = ST_IDLE;
              w_fin_ack = 1'b1;
            end
`ifdef CCIP_ETH_CSR_TIMEOUT_EN
            else if (w_expire) begin
              w_next    = ST_IDLE;
              w_fin_tmo = 1'b1;
            end
`endif
          end
          default: w_next = ST_IDLE;
        endcase
      end

      always_comb begin
        w_busy = (r_state == ST_REQ);
      end

      always_ff @(posedge clk or posedge pck_cp2af_softReset_T1) begin
        if (pck_cp2af_softReset_T1) begin
          r_ctrl     <= '0;
          r_wr_data  <= '0;
          r_rd_data  <= '0;
          r_eth_addr <= '0;
          r_done     <= 1'b0;
          r_ovr      <= 1'b0;
        end else begin
          if (w_wr_ctrl && !w_busy)        r_ctrl <= mmio_din[31:0];
          else if (w_fin_ack || w_fin_tmo) r_ctrl[17:16] <= 2'b00;
          if (w_start)                     r_eth_addr <= mmio_din[31:0];
          if (w_wr_wdat && !w_busy)        r_wr_data <= mmio_din[31:0];
          if (w_fin_ack && r_ctrl[17])     r_rd_data <= eth_rd_data[ch*32 +: 32];
          // Hardware set beats a same-cycle write-1-to-clear.
          r_done <= w_fin_ack || (r_done && !w_clr[1]);
          r_ovr  <= (w_busy && (w_wr_ctrl || w_wr_wdat)) || (r_ovr && !w_clr[3]);
        end
      end

`ifdef CCIP_ETH_CSR_TIMEOUT_EN
      always_ff @(posedge clk or posedge pck_cp2af_softReset_T1) begin
        if (pck_cp2af_softReset_T1) begin
          r_cnt <= '0;
          r_tmo <= 1'b0;
        end else begin
          if (w_start)     r_cnt <= '0;
          else if (w_busy) r_cnt <= r_cnt + 1'b1;
          r_tmo <= w_fin_tmo || (r_tmo && !w_clr[2]);
        end
      end
`else
      assign r_tmo = 1'b0;
`endif

      assign eth_req[ch]              = w_busy;
      assign eth_ctrl_addr[ch*32 +: 32] = r_eth_addr;
      assign eth_wr_data[ch*32 +: 32] = r_wr_data;
      assign w_ctrl_all[ch*32 +: 32]  = r_ctrl;
      assign w_wdat_all[ch*32 +: 32]  = r_wr_data;
      assign w_rdat_all[ch*32 +: 32]  = r_rd_data;
      assign w_stat_all[ch*4 +: 4]    = {r_ovr, r_tmo, r_done, w_busy};
    end else begin : g_off
      assign w_ctrl_all[ch*32 +: 32] = '0;
      assign w_wdat_all[ch*32 +: 32] = '0;
      assign w_rdat_all[ch*32 +: 32] = '0;
      assign w_stat_all[ch*4 +: 4]   = '0;
    end
  end

  logic [63:0] w_init_rd, w_rd_data;

  always_comb begin
    w_init_rd              = '0;
    w_init_rd[NUM_CH-1:0]  = r_init_start;
    w_init_rd[32 +: NUM_CH] = r_init_done;
    w_rd_data              = '0;
    if (w_glb_hit) begin
      case (w_glb_idx)
        3'd0:    w_rd_data = DFH;
        3'd1:    w_rd_data = AFU_ID_L;
        3'd2:    w_rd_data = AFU_ID_H;
        3'd3:    w_rd_data = r_scratch;
        3'd4:    w_rd_data = w_init_rd;
        default: w_rd_data = '0;
      endcase
    end else if (w_ch_hit) begin
      case (w_reg_idx)
        2'd0:    w_rd_data = {32'd0, w_ctrl_all[{w_ch_idx, 5'd0} +: 32]};
        2'd1:    w_rd_data = {32'd0, w_wdat_all[{w_ch_idx, 5'd0} +: 32]};
        2'd2:    w_rd_data = {32'd0, w_rdat_all[{w_ch_idx, 5'd0} +: 32]};
        default: w_rd_data = {60'd0, w_stat_all[{w_ch_idx, 2'd0} +: 4]};
      endcase
    end
  end

  // Two-stage read pipeline: data is snapshotted in the request cycle.
  logic        r_rd_v1;
  logic [8:0]  r_tid1;
  logic [63:0] r_dat1;

  always_ff @(posedge clk or posedge pck_cp2af_softReset_T1) begin
    if (pck_cp2af_softReset_T1) begin
      r_rd_v1   <= 1'b0;
      r_tid1    <= '0;
      r_dat1    <= '0;
      rsp_valid <= 1'b0;
      rsp_tid   <= '0;
      rsp_data  <= '0;
    end else begin
      r_rd_v1   <= mmio_rd_en;
      rsp_valid <= r_rd_v1;
      if (mmio_rd_en) begin
        r_tid1 <= mmio_tid;
        r_dat1 <= w_rd_data;
      end
      if (r_rd_v1) begin
        rsp_tid  <= r_tid1;
        rsp_data <= r_dat1;
      end
    end
  end

endmodule

// File: tb/tb_ccip_eth_csr_mc.sv
// Self-checking bench for ccip_eth_csr_mc: constant/register table, directed channel sequences,
// and a randomized run scored against a transaction-level register model.
module tb_ccip_eth_csr_mc;

  localparam int          NCH = 4;
  localparam int          TO  = 16;
  localparam logic [63:0] IDL = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] IDH = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DFH = 64'h1000_0000_0000_0001;

  logic               clk, rst;
  logic               mmio_wr_en, mmio_rd_en;
  logic [15:0]        mmio_addr;
  logic [8:0]         mmio_tid;
  logic [63:0]        mmio_din;
  logic               rsp_valid;
  logic [8:0]         rsp_tid;
  logic [63:0]        rsp_data;
  logic [32*NCH-1:0]  eth_ctrl_addr, eth_wr_data, eth_rd_data;
  logic [NCH-1:0]     eth_req, eth_ack, init_start, init_done;

  ccip_eth_csr_mc #(.NUM_CH(NCH), .AFU_ID_L(IDL), .AFU_ID_H(IDH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .pck_cp2af_softReset_T1(rst),
    .mmio_wr_en(mmio_wr_en), .mmio_rd_en(mmio_rd_en), .mmio_addr(mmio_addr),
    .mmio_tid(mmio_tid), .mmio_din(mmio_din),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .eth_ctrl_addr(eth_ctrl_addr), .eth_wr_data(eth_wr_data), .eth_req(eth_req),
    .eth_ack(eth_ack), .eth_rd_data(eth_rd_data),
    .init_start(init_start), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [8:0] tid_ctr = 9'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ch_addr(input int ch, input int r);
    return 16'((32'h100 + 32 * ch + 8 * r) >> 2);
  endfunction

  // All tasks start driving at the current negedge and return on a negedge.
  task automatic mmio_write(input logic [15:0] a, input logic [63:0] d);
    mmio_wr_en = 1'b1; mmio_addr = a; mmio_din = d;
    @(negedge clk);
    mmio_wr_en = 1'b0;
  endtask

  task automatic mmio_read(input logic [15:0] a, output logic [63:0] d);
    logic [8:0] t;
    t = tid_ctr; tid_ctr = tid_ctr + 9'd37;
    mmio_rd_en = 1'b1; mmio_addr = a; mmio_tid = t;
    @(negedge clk);
    mmio_rd_en = 1'b0;
    check("rsp_valid_t1", rsp_valid, 0);
    @(negedge clk);
    check("rsp_valid_t2", rsp_valid, 1);
    check("rsp_tid", rsp_tid, t);
    d = rsp_data;
  endtask

  task automatic read_check(input string name, input logic [15:0] a, input logic [63:0] exp);
    logic [63:0] d;
    mmio_read(a, d);
    check(name, d, exp);
  endtask

  task automatic pulse_ack(input int ch, input logic [31:0] data);
    eth_ack[ch] = 1'b1; eth_rd_data[ch*32 +: 32] = data;
    @(negedge clk);
    eth_ack = '0;
  endtask

  // ---------------- reference model ----------------
  logic [31:0]    m_ctrl [NCH], m_wrd [NCH], m_rdd [NCH], m_eaddr [NCH];
  int             m_start [NCH];
  logic [NCH-1:0] m_busy, m_done, m_ovr, m_tmo, m_init, m_idone;
  logic [63:0]    m_scr;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ctrl[c] = '0; m_wrd[c] = '0; m_rdd[c] = '0; m_eaddr[c] = '0; m_start[c] = 0;
    end
    m_busy = '0; m_done = '0; m_ovr = '0; m_tmo = '0; m_init = '0; m_idone = '0; m_scr = '0;
  endfunction

  // A request accepted on edge S times out on edge S+TO unless acked by then.
  function automatic void model_expire(input int now);
`ifdef CCIP_ETH_CSR_TIMEOUT_EN
    for (int c = 0; c < NCH; c++)
      if (m_busy[c] && (now - m_start[c] >= TO)) begin
        m_busy[c] = 1'b0; m_tmo[c] = 1'b1; m_ctrl[c][17:16] = 2'b00;
      end
`else
    if (now < 0) m_busy = '0;
`endif
  endfunction

  function automatic logic [63:0] model_read(input logic [15:0] a);
    int b, c, r;
    logic [63:0] v;
    b = int'(a) * 4;
    v = '0;
    if (a[0]) return '0;
    if (b < 'h100) begin
      case (b)
        0:  v = DFH;
        8:  v = IDL;
        16: v = IDH;
        24: v = m_scr;
        32: begin v[NCH-1:0] = m_init; v[32 +: NCH] = m_idone; end
        default: v = '0;
      endcase
    end else if (b < 'h200) begin
      c = (b - 'h100) / 32; r = (b % 32) / 8;
      if (c < NCH)
        case (r)
          0: v = {32'd0, m_ctrl[c]};
          1: v = {32'd0, m_wrd[c]};
          2: v = {32'd0, m_rdd[c]};
          default: v = {60'd0, m_ovr[c], m_tmo[c], m_done[c], m_busy[c]};
        endcase
    end
    return v;
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [63:0] d, input int edge_no);
    int b, c, r;
    b = int'(a) * 4;
    if (a[0]) return;
    if (b == 24) m_scr = d;
    if (b == 32) m_init = d[NCH-1:0];
    if (b >= 'h100 && b < 'h200) begin
      c = (b - 'h100) / 32; r = (b % 32) / 8;
      if (c >= NCH) return;
      case (r)
        0: if (m_busy[c]) m_ovr[c] = 1'b1;
           else begin
             m_ctrl[c] = d[31:0];
             if (d[17] || d[16]) begin
               m_busy[c] = 1'b1; m_eaddr[c] = d[31:0]; m_start[c] = edge_no;
             end
           end
        1: if (m_busy[c]) m_ovr[c] = 1'b1; else m_wrd[c] = d[31:0];
        3: begin
             if (d[1]) m_done[c] = 1'b0;
             if (d[2]) m_tmo[c]  = 1'b0;
             if (d[3]) m_ovr[c]  = 1'b0;
           end
        default: ;
      endcase
    end
  endfunction

  function automatic void model_ack(input int c, input logic [31:0] data);
    if (!m_busy[c]) return;
    m_busy[c] = 1'b0; m_done[c] = 1'b1;
    if (m_ctrl[c][17]) m_rdd[c] = data;
    m_ctrl[c][17:16] = 2'b00;
  endfunction

  function automatic logic [15:0] rand_addr(input int max_ch);
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return 16'($urandom_range(0, 'h7F)) | 16'd1;
    if (s <= 3) return 16'($urandom_range(0, 5) * 2);
    return ch_addr($urandom_range(0, max_ch), $urandom_range(0, 3));
  endfunction

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [63:0] din;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vt[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [15:0] a;
    int          c, op;
    logic [31:0] dat;

    vt.push_back('{1'b0, 16'h0000, 64'h0, DFH, "dfh"});
    vt.push_back('{1'b0, 16'h0002, 64'h0, IDL, "afu_id_l"});
    vt.push_back('{1'b0, 16'h0004, 64'h0, IDH, "afu_id_h"});
    vt.push_back('{1'b0, 16'h0006, 64'h0, 64'h0, "scratch_rst"});
    vt.push_back('{1'b0, 16'h0008, 64'h0, 64'h0, "init_rst"});
    vt.push_back('{1'b0, ch_addr(0, 0), 64'h0, 64'h0, "ch0_ctrl_rst"});
    vt.push_back('{1'b0, ch_addr(3, 3), 64'h0, 64'h0, "ch3_stat_rst"});
    vt.push_back('{1'b1, 16'h0006, 64'hDEAD_BEEF_0123_4567, 64'h0, ""});
    vt.push_back('{1'b0, 16'h0006, 64'h0, 64'hDEAD_BEEF_0123_4567, "scratch_rw"});
    vt.push_back('{1'b1, 16'h0007, 64'h1, 64'h0, ""});
    vt.push_back('{1'b0, 16'h0006, 64'h0, 64'hDEAD_BEEF_0123_4567, "misaligned_wr_ignored"});
    vt.push_back('{1'b0, 16'h0007, 64'h0, 64'h0, "misaligned_rd_zero"});
    vt.push_back('{1'b1, 16'h0000, 64'h0, 64'h0, ""});
    vt.push_back('{1'b0, 16'h0000, 64'h0, DFH, "dfh_ro"});
    vt.push_back('{1'b1, ch_addr(5, 0), 64'h3_0000, 64'h0, ""});
    vt.push_back('{1'b0, ch_addr(5, 0), 64'h0, 64'h0, "ch5_absent"});
    vt.push_back('{1'b1, 16'h0008, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, ""});
    vt.push_back('{1'b0, 16'h0008, 64'h0, 64'hF, "init_rw"});
    vt.push_back('{1'b1, ch_addr(0, 1), 64'h1234_5678_AABB_CCDD, 64'h0, ""});
    vt.push_back('{1'b0, ch_addr(0, 1), 64'h0, 64'hAABB_CCDD, "ch0_wrdata_32b"});
    vt.push_back('{1'b1, ch_addr(0, 0), 64'h0000_1234, 64'h0, ""});
    vt.push_back('{1'b0, ch_addr(0, 0), 64'h0, 64'h1234, "ch0_ctrl_noop"});
    vt.push_back('{1'b0, ch_addr(0, 3), 64'h0, 64'h0, "ch0_noop_no_txn"});
    vt.push_back('{1'b0, 16'h000A, 64'h0, 64'h0, "unmapped_zero"});

    rst = 1'b1; mmio_wr_en = 0; mmio_rd_en = 0; mmio_addr = '0; mmio_tid = '0; mmio_din = '0;
    eth_ack = '0; eth_rd_data = '0; init_done = '0;
    repeat (3) @(negedge clk);
    check("rst_eth_req", eth_req, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_init_start", init_start, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wr) mmio_write(vt[i].addr, vt[i].din);
      else          read_check(vt[i].name, vt[i].addr, vt[i].exp);
    end
    check("init_start_port", init_start, 4'hF);
    check("noop_no_req", eth_req, 0);
    mmio_write(16'h0008, 64'h0);

    // Back-to-back reads with tids 1/2/3.
    mmio_rd_en = 1; mmio_addr = 16'h0000; mmio_tid = 9'd1; @(negedge clk);
    check("b2b_t1_idle", rsp_valid, 0);
    mmio_addr = 16'h0002; mmio_tid = 9'd2; @(negedge clk);
    check("b2b_v1", rsp_valid, 1); check("b2b_tid1", rsp_tid, 1); check("b2b_d1", rsp_data, DFH);
    mmio_addr = 16'h0004; mmio_tid = 9'd3; @(negedge clk);
    mmio_rd_en = 0;
    check("b2b_v2", rsp_valid, 1); check("b2b_tid2", rsp_tid, 2); check("b2b_d2", rsp_data, IDL);
    @(negedge clk);
    check("b2b_v3", rsp_valid, 1); check("b2b_tid3", rsp_tid, 3); check("b2b_d3", rsp_data, IDH);
    @(negedge clk);
    check("b2b_end", rsp_valid, 0);

    // ch2 write transaction.
    mmio_write(ch_addr(2, 1), 64'hCAFE_0001);
    mmio_write(ch_addr(2, 0), 64'h0001_0040);
    check("ch2_req", eth_req[2], 1);
    check("ch2_addr", eth_ctrl_addr[2*32 +: 32], 32'h0001_0040);
    check("ch2_wdata", eth_wr_data[2*32 +: 32], 32'hCAFE_0001);
    repeat (5) @(negedge clk);
    pulse_ack(2, 32'h0);
    check("ch2_req_drop", eth_req[2], 0);
    read_check("ch2_status_done", ch_addr(2, 3), 64'h2);
    read_check("ch2_ctrl_selfclr", ch_addr(2, 0), 64'h40);

    // ch0 read transaction and W1C.
    mmio_write(ch_addr(0, 0), 64'h0002_0010);
    pulse_ack(0, 32'h1234_5678);
    read_check("ch0_rddata", ch_addr(0, 2), 64'h1234_5678);
    read_check("ch0_status_done", ch_addr(0, 3), 64'h2);
    mmio_write(ch_addr(0, 3), 64'h2);
    read_check("ch0_status_w1c", ch_addr(0, 3), 64'h0);

    // W1C of done in the same cycle as the ack that sets it: set wins.
    mmio_write(ch_addr(0, 0), 64'h0002_0010);
    mmio_wr_en = 1; mmio_addr = ch_addr(0, 3); mmio_din = 64'h2;
    eth_ack[0] = 1'b1; eth_rd_data[31:0] = 32'h5555_AAAA;
    @(negedge clk);
    mmio_wr_en = 0; eth_ack = '0;
    read_check("set_beats_w1c", ch_addr(0, 3), 64'h2);
    read_check("ch0_rddata2", ch_addr(0, 2), 64'h5555_AAAA);
    mmio_write(ch_addr(0, 3), 64'hF);

    // ch1 overrun.
    mmio_write(ch_addr(1, 0), 64'h0002_0020);
    mmio_write(ch_addr(1, 0), 64'h0001_0099);
    mmio_write(ch_addr(1, 1), 64'h7777_7777);
    read_check("ch1_status_ovr", ch_addr(1, 3), 64'h9);
    check("ch1_addr_kept", eth_ctrl_addr[1*32 +: 32], 32'h0002_0020);
    read_check("ch1_ctrl_kept", ch_addr(1, 0), 64'h0002_0020);
    read_check("ch1_wdata_kept", ch_addr(1, 1), 64'h0);
    pulse_ack(1, 32'hABCD_0001);
    read_check("ch1_status_done_ovr", ch_addr(1, 3), 64'hA);
    mmio_write(ch_addr(1, 3), 64'h8);
    read_check("ch1_ovr_cleared", ch_addr(1, 3), 64'h2);
    pulse_ack(1, 32'hFFFF_0000);
    read_check("ack_idle_ignored", ch_addr(1, 2), 64'hABCD_0001);
    mmio_write(ch_addr(1, 3), 64'hF);

    // ch3 with no ack.
    mmio_write(ch_addr(3, 0), 64'h0001_0003);
`ifdef CCIP_ETH_CSR_TIMEOUT_EN
    repeat (TO - 1) @(negedge clk);
    check("tmo_req_held", eth_req[3], 1);
    @(negedge clk);
    check("tmo_req_drop", eth_req[3], 0);
    read_check("tmo_status", ch_addr(3, 3), 64'h4);
    read_check("tmo_ctrl_clr", ch_addr(3, 0), 64'h3);
    mmio_write(ch_addr(3, 3), 64'h4);
    mmio_write(ch_addr(3, 0), 64'h0002_0003);
    repeat (TO - 1) @(negedge clk);
    pulse_ack(3, 32'h0BAD_F00D);
    read_check("ack_beats_tmo", ch_addr(3, 3), 64'h2);
    read_check("ack_beats_tmo_data", ch_addr(3, 2), 64'h0BAD_F00D);
`else
    repeat (1000) @(negedge clk);
    check("notmo_req_held", eth_req[3], 1);
    read_check("notmo_status", ch_addr(3, 3), 64'h1);
    pulse_ack(3, 32'h0);
    read_check("notmo_done", ch_addr(3, 3), 64'h2);
`endif

    // Reset mid-transaction with a read in flight.
    mmio_write(16'h0008, 64'h5);
    mmio_write(ch_addr(0, 0), 64'h0002_0010);
    check("pre_rst_req", eth_req[0], 1);
    mmio_rd_en = 1; mmio_addr = 16'h0000; mmio_tid = 9'h1FF;
    @(negedge clk);
    mmio_rd_en = 0;
    #2 rst = 1'b1;
    #1;
    check("rst_async_req", eth_req, 0);
    check("rst_async_init", init_start, 0);
    check("rst_async_rsp", rsp_valid, 0);
    repeat (2) begin @(negedge clk); check("rst_no_rsp", rsp_valid, 0); end
    rst = 1'b0;
    repeat (2) begin @(negedge clk); check("post_rst_no_rsp", rsp_valid, 0); end
    check("post_rst_addr", eth_ctrl_addr, 0);
    check("post_rst_wdata", eth_wr_data, 0);
    read_check("post_rst_scratch", 16'h0006, 64'h0);
    read_check("post_rst_init", 16'h0008, 64'h0);
    for (int i = 0; i < NCH; i++)
      for (int r = 0; r < 4; r++) read_check("post_rst_ch", ch_addr(i, r), 64'h0);

    // Randomized run against the model.
    model_reset();
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 9);
      model_expire(cyc);
      if (op <= 3) begin
        a = (op == 3) ? 16'($urandom_range(3, 4) * 2) : ch_addr($urandom_range(0, NCH), $urandom_range(0, 3));
        d = {$urandom, $urandom};
        model_write(a, d, cyc + 1);
        mmio_write(a, d);
      end else if (op <= 5) begin
        c = $urandom_range(0, NCH - 1);
        dat = $urandom;
        model_ack(c, dat);
        pulse_ack(c, dat);
      end else if (op <= 8) begin
        a = rand_addr(7);
        read_check("rand_read", a, model_read(a));
      end else begin
        init_done = 4'($urandom);
        m_idone = init_done;
        @(negedge clk);
      end
      model_expire(cyc);
      for (int i = 0; i < NCH; i++) begin
        check("rand_eth_req", eth_req[i], m_busy[i]);
        check("rand_eth_addr", eth_ctrl_addr[i*32 +: 32], m_eaddr[i]);
        check("rand_eth_wdata", eth_wr_data[i*32 +: 32], m_wrd[i]);
      end
      check("rand_init_start", init_start, m_init);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
